inst_sram_arbiter: RTL

Shares the single-port, synchronous-read instruction SRAM between the IF stage's fetch port and a loader/debug port that writes programs and reads back memory. It sits between `if_stage` and the SRAM macro. It drives the IF stage's `inst_sram_en_toif` permission so IF only fetches in cycles it owns. It also holds IF's last fetched word so loader traffic cannot corrupt an instruction that IF is stalled on.

---
 rtl/inst_sram_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/inst_sram_arbiter.sv
// -----------------------------------------------------------------------------
// inst_sram_arbiter
//
// Shares the single-port, synchronous-read instruction SRAM between the IF
// stage fetch port and a loader/debug port. IF only fetches while it holds the
// registered permission if_grant. The loader gains the port through a one-cycle
// drain window followed by a burst of at most LD_BURST beats, after which the
// port is handed back to IF. The last word fetched by IF is held so loader
// traffic cannot disturb an instruction IF is stalled on.
//
// Optional feature macro: INST_ARB_BOOT_HOLD_EN
//   defined   : reset into S_BOOT; the loader owns the port and IF is held off
//               until ld_done is pulsed.
//   undefined : S_BOOT is not built; reset into S_IF with if_grant = 1.
//
// Parameters:
//   ADDR_W    address width on all ports
//   LD_BURST  maximum consecutive loader beats per ownership window (>= 1)
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   if_en, if_addr   IF read request and address
//   if_grant         registered fetch permission to IF
//   if_rdata         instruction data to IF (live or held)
//   ld_req, ld_we    loader request, write qualifier
//   ld_addr          loader address
//   ld_wdata         loader write data
//   ld_done          end-of-load pulse (only acted on in S_BOOT)
//   ld_gnt           loader beat accepted this cycle
//   ld_rvalid        loader read data valid
//   ld_rdata         loader read data
//   sram_*           SRAM macro port, read data returns one cycle after enable
// -----------------------------------------------------------------------------
module inst_sram_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int LD_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_grant,
    output logic [31:0]       if_rdata,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    input  logic              ld_done,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,

    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    // state   | meaning
    // S_BOOT  | loader owns the port until ld_done, IF blocked
    // S_IF    | IF owns the port
    // S_DRAIN | one idle cycle, last IF read data returns
    // S_LD    | loader burst, at most LD_BURST beats
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_IF    = 2'd1,
        S_DRAIN = 2'd2,
        S_LD    = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(LD_BURST + 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(LD_BURST - 1);

`ifdef INST_ARB_BOOT_HOLD_EN
    localparam state_t RESET_STATE = S_BOOT;
    localparam logic   RESET_GRANT = 1'b0;
`else
    localparam state_t RESET_STATE = S_IF;
    localparam logic   RESET_GRANT = 1'b1;

    // ld_done only matters in S_BOOT, which is absent from this build.
    logic unused_ld_done;
    assign unused_ld_done = ld_done;
`endif

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic              if_rd_q;
    logic              ld_rd_q;
    logic [31:0]       if_hold;
    logic              ld_owns;

    // Loader owns the port in S_LD (and S_BOOT when built in).
    always_comb begin
        ld_owns = (state == S_LD);
`ifdef INST_ARB_BOOT_HOLD_EN
        if (state == S_BOOT) begin
            ld_owns = 1'b1;
        end
`endif
    end

    // ld_gnt is gated by reset so nothing is accepted while reset is held.
    assign ld_gnt = ld_owns && ld_req && !reset;

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (state == S_IF) begin
            sram_en   = if_en;
            sram_addr = if_addr;
        end else if (ld_owns) begin
            sram_en    = ld_gnt;
            sram_we    = ld_we;
            sram_addr  = ld_addr;
            sram_wdata = ld_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESET_STATE;
            if_grant <= RESET_GRANT;
            beat_cnt <= '0;
        end else begin
            case (state)
`ifdef INST_ARB_BOOT_HOLD_EN
                S_BOOT: begin
                    if (ld_done) begin
                        state    <= S_IF;
                        if_grant <= 1'b1;
                    end
                end
`endif
                S_IF: begin
                    if (ld_req) begin
                        state    <= S_DRAIN;
                        if_grant <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    state <= S_LD;
                end
                S_LD: begin
                    // Leave on an idle loader or on the last beat of the window.
                    if (!ld_req || (beat_cnt == BEAT_LAST)) begin
                        state    <= S_IF;
                        if_grant <= 1'b1;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= S_IF;
                    if_grant <= 1'b1;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // Read tracking: which port the SRAM data in the current cycle belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rd_q <= 1'b0;
            ld_rd_q <= 1'b0;
            if_hold <= '0;
        end else begin
            if_rd_q <= if_en && (state == S_IF);
            ld_rd_q <= ld_gnt && !ld_we;
            if (if_rd_q) begin
                if_hold <= sram_rdata;
            end
        end
    end

    assign ld_rvalid = ld_rd_q;
    assign ld_rdata  = sram_rdata;

    // Outside an IF return cycle, IF keeps seeing its last fetched word.
    assign if_rdata  = if_rd_q ? sram_rdata : if_hold;

endmodule
